// File: rtl/ysyx_23060136_mem_lsu_pkg.sv
// Shared LSU definitions: funct3 encodings, FSM state type and the alignment rule.
package ysyx_23060136_LSU_PKG;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;

    function automatic logic lsu_misalign(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            LSU_H, LSU_HU: return off[0];
            LSU_W:         return off != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060136_mem_lsu_load_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module ysyx_23060136_load_align
    import ysyx_23060136_LSU_PKG::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = word[{off[1], 4'b0000} +: 16];
        case (funct3)
            LSU_B:   data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LSU_BU:  data = {{(DATA_W-8){1'b0}}, byte_sel};
            LSU_H:   data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LSU_HU:  data = {{(DATA_W-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/ysyx_23060136_mem_lsu.sv
// MEM-stage load/store unit: one valid/ready bus transaction per access, stalls the pipe until done.
module ysyx_23060136_mem_lsu
    import ysyx_23060136_LSU_PKG::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_i_valid,
    input  logic              MEM_i_ren,
    input  logic              MEM_i_wen,
    input  logic [2:0]        MEM_i_funct3,
    input  logic [ADDR_W-1:0] MEM_i_addr,
    input  logic [DATA_W-1:0] MEM_i_wdata,
    input  logic              FORWARD_stallME,
    input  logic              FORWARD_flushME,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_rdata,
    output logic [DATA_W-1:0] MEM_o_rdata,
    output logic              MEM_o_stall_req,
    output logic              MEM_o_misalign
);

    lsu_state_t        state;
    logic              discard;
    logic [1:0]        ld_off;
    logic [2:0]        ld_funct3;
    logic [DATA_W-1:0] rbuf;
    logic [DATA_W-1:0] align_data;
    logic [DATA_W-1:0] store_data;
    logic [3:0]        store_strb;
    logic              mem_op;
    logic              misalign;
    logic              access;
    logic              issue;

    assign mem_op   = MEM_i_valid & (MEM_i_ren | MEM_i_wen);
    assign misalign = mem_op & lsu_misalign(MEM_i_funct3, MEM_i_addr[1:0]);
    assign access   = mem_op & ~misalign;
    assign issue    = (state == IDLE) & access & ~FORWARD_flushME;

    assign MEM_o_misalign  = ~rst & misalign;
    assign MEM_o_stall_req = ~rst & (issue | (state == REQ) | (state == RESP));
    assign MEM_o_rdata     = req_we ? '0 : align_data;

    always_comb begin
        store_data = MEM_i_wdata;
        store_strb = 4'hF;
        case (MEM_i_funct3)
            LSU_B: begin
                store_data = {4{MEM_i_wdata[7:0]}};
                store_strb = 4'b0001 << MEM_i_addr[1:0];
            end
            LSU_H: begin
                store_data = {2{MEM_i_wdata[15:0]}};
                store_strb = 4'b0011 << {MEM_i_addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    ysyx_23060136_load_align #(.DATA_W(DATA_W)) u_load_align (
        .word   (rbuf),
        .off    (ld_off),
        .funct3 (ld_funct3),
        .data   (align_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= 4'h0;
            ld_off    <= 2'b00;
            ld_funct3 <= 3'b000;
            rbuf      <= '0;
            discard   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    state     <= REQ;
                    req_valid <= 1'b1;
                    req_we    <= MEM_i_wen;
                    req_addr  <= {MEM_i_addr[ADDR_W-1:2], 2'b00};
                    req_wdata <= MEM_i_wen ? store_data : '0;
                    req_wstrb <= MEM_i_wen ? store_strb : 4'h0;
                    ld_off    <= MEM_i_addr[1:0];
                    ld_funct3 <= MEM_i_funct3;
                    discard   <= 1'b0;
                end
                // A kill after issue cannot recall the bus request; remember to drop its response.
                REQ: begin
                    if (FORWARD_flushME) discard <= 1'b1;
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (resp_valid) begin
                        if (discard | FORWARD_flushME) begin
                            state   <= IDLE;
                            discard <= 1'b0;
                        end else begin
                            if (!req_we) rbuf <= resp_rdata;
                            state <= DONE;
                        end
                    end else if (FORWARD_flushME) begin
                        discard <= 1'b1;
                    end
                end
                DONE: if (!FORWARD_stallME || FORWARD_flushME) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
